// File: rtl/morse_tx.sv
// morse_tx: Morse keyer. Accepts one ASCII character per valid/ready
// handshake, looks up its ITU code and keys it out as an on/off envelope
// with unit timing (dot 1, dash 3, symbol gap 1, letter gap 3, word gap 7).
// The looked-up code is also held on morse_length/morse_input in the
// decoder's length/bit format so the two blocks can be looped back.
module morse_tx #(
   parameter int UNIT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       err,
   output logic       done,
   output logic [3:0] morse_length,
   output logic [7:0] morse_input
);

   localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, MARK, SGAP, LGAP, WGAP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cyc;
   logic [1:0]    unit;
   logic [7:0]    sh;      // left-aligned symbols; sh[7] is the symbol being keyed
   logic [2:0]    left;    // symbols still to send after the current one

   logic [7:0]    uc;
   logic [11:0]   lk;      // {length, bits}
   logic          lk_ok, lk_space;
   logic          accept, unit_end;
   logic          load, shift, done_n, err_n;

   assign accept   = char_valid && char_ready;
   assign unit_end = (cyc == CYC_LAST);

   // Code lookup: lower case folds onto upper case, space is a word gap
   always_comb begin
      uc       = ((char_data >= 8'h61) && (char_data <= 8'h7A)) ? (char_data - 8'h20) : char_data;
      lk       = 12'h000;
      lk_ok    = 1'b1;
      lk_space = 1'b0;
      case (uc)
         8'h41: lk = {4'd2, 8'h01};   // A .-
         8'h42: lk = {4'd4, 8'h08};   // B -...
         8'h43: lk = {4'd4, 8'h0A};   // C -.-.
         8'h44: lk = {4'd3, 8'h04};   // D -..
         8'h45: lk = {4'd1, 8'h00};   // E .
         8'h46: lk = {4'd4, 8'h02};   // F ..-.
         8'h47: lk = {4'd3, 8'h06};   // G --.
         8'h48: lk = {4'd4, 8'h00};   // H ....
         8'h49: lk = {4'd2, 8'h00};   // I ..
         8'h4A: lk = {4'd4, 8'h07};   // J .---
         8'h4B: lk = {4'd3, 8'h05};   // K -.-
         8'h4C: lk = {4'd4, 8'h04};   // L .-..
         8'h4D: lk = {4'd2, 8'h03};   // M --
         8'h4E: lk = {4'd2, 8'h02};   // N -.
         8'h4F: lk = {4'd3, 8'h07};   // O ---
         8'h50: lk = {4'd4, 8'h06};   // P .--.
         8'h51: lk = {4'd4, 8'h0D};   // Q --.-
         8'h52: lk = {4'd3, 8'h02};   // R .-.
         8'h53: lk = {4'd3, 8'h00};   // S ...
         8'h54: lk = {4'd1, 8'h01};   // T -
         8'h55: lk = {4'd3, 8'h01};   // U ..-
         8'h56: lk = {4'd4, 8'h01};   // V ...-
         8'h57: lk = {4'd3, 8'h03};   // W .--
         8'h58: lk = {4'd4, 8'h09};   // X -..-
         8'h59: lk = {4'd4, 8'h0B};   // Y -.--
         8'h5A: lk = {4'd4, 8'h0C};   // Z --..
         8'h30: lk = {4'd5, 8'h1F};   // 0 -----
         8'h31: lk = {4'd5, 8'h0F};   // 1 .----
         8'h32: lk = {4'd5, 8'h07};   // 2 ..---
         8'h33: lk = {4'd5, 8'h03};   // 3 ...--
         8'h34: lk = {4'd5, 8'h01};   // 4 ....-
         8'h35: lk = {4'd5, 8'h00};   // 5 .....
         8'h36: lk = {4'd5, 8'h10};   // 6 -....
         8'h37: lk = {4'd5, 8'h18};   // 7 --...
         8'h38: lk = {4'd5, 8'h1C};   // 8 ---..
         8'h39: lk = {4'd5, 8'h1E};   // 9 ----.
         8'h2E: lk = {4'd6, 8'h15};   // . .-.-.-
         8'h2C: lk = {4'd6, 8'h33};   // , --..--
         8'h3F: lk = {4'd6, 8'h0C};   // ? ..--..
         8'h27: lk = {4'd6, 8'h1E};   // ' .----.
         8'h2F: lk = {4'd5, 8'h12};   // / -..-.
         8'h28: lk = {4'd5, 8'h16};   // ( -.--.
         8'h29: lk = {4'd6, 8'h2D};   // ) -.--.-
         8'h26: lk = {4'd5, 8'h08};   // & .-...
         8'h3A: lk = {4'd6, 8'h38};   // : ---...
         8'h3B: lk = {4'd6, 8'h2A};   // ; -.-.-.
         8'h3D: lk = {4'd5, 8'h11};   // = -...-
         8'h2B: lk = {4'd5, 8'h0A};   // + .-.-.
         8'h2D: lk = {4'd6, 8'h21};   // - -....-
         8'h5F: lk = {4'd6, 8'h0D};   // _ ..--.-
         8'h40: lk = {4'd6, 8'h1A};   // @ .--.-.
         8'h21: lk = {4'd6, 8'h2B};   // ! -.-.--
         8'h20: lk_space = 1'b1;      // word gap, no symbols
         default: lk_ok = 1'b0;
      endcase
   end

   // Next state: each keyed state ends on the last cycle of its final unit
   always_comb begin
      state_n = state;
      load    = 1'b0;
      shift   = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!lk_ok) begin
                  err_n = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = lk_space ? WGAP : MARK;
               end
            end
         end
         MARK: begin
            if (unit_end && (unit == (sh[7] ? 2'd2 : 2'd0))) begin
               shift   = 1'b1;
               state_n = (left == 3'd0) ? LGAP : SGAP;
            end
         end
         SGAP: begin
            if (unit_end) state_n = MARK;
         end
         LGAP: begin
            if (unit_end && (unit == 2'd2)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         WGAP: begin
            // 4 units here plus the 3-unit letter gap before it make 7
            if (unit_end && (unit == 2'd3)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, unit timer and registered outputs (derived from next state so
   // they line up with the state they describe)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc        <= '0;
         unit       <= 2'd0;
         char_ready <= 1'b0;
         key_out    <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         if ((state_n != state) || (state_n == IDLE)) begin
            cyc  <= '0;
            unit <= 2'd0;
         end else if (unit_end) begin
            cyc  <= '0;
            unit <= unit + 2'd1;
         end else begin
            cyc  <= cyc + 1'b1;
         end
         char_ready <= (state_n == IDLE);
         key_out    <= (state_n == MARK);
         busy       <= (state_n != IDLE);
         err        <= err_n;
         done       <= done_n;
      end
   end

   // Symbol shift register and the held code outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh           <= 8'h00;
         left         <= 3'd0;
         morse_length <= 4'd0;
         morse_input  <= 8'h00;
      end else if (load) begin
         sh           <= lk[7:0] << (4'd8 - lk[11:8]);
         left         <= 3'(lk[11:8] - 4'd1);
         morse_length <= lk[11:8];
         morse_input  <= lk[7:0];
      end else if (shift) begin
         sh           <= {sh[6:0], 1'b0};
         left         <= left - 3'd1;
      end
   end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse keyer: accepts one ASCII character per valid/ready handshake and keys it out serially as an on/off tone envelope with standard unit timing. Dot = 1 unit, dash = 3 units, intra-letter gap = 1 unit, inter-letter gap = 3 units, word gap = 7 units. It is the transmit end of the Morse path, feeding the buzzer/LED.

It also exposes the looked-up code in the same length/bit format the Morse decoder consumes, so the two blocks can be looped back for self-test.

## Interface
- UNIT_CYCLES, default 1000000: clock cycles per Morse unit; legal range ≥1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- char_valid  in  1  an ASCII character is offered on char_data.
- char_data  in  8  ASCII character.
- char_ready  out  1  block can accept a character this cycle; high only in IDLE.
- key_out  out  1  1 = tone on (mark), 0 = silence.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  one-cycle pulse: the accepted character is unsupported.
- done  out  1  one-cycle pulse: the character (including its trailing gap) is complete.
- morse_length  out  4  symbol count of the current character (1..7); 0 for space.
- morse_input  out  8  symbol bits; bit [morse_length-1] is sent first; 0 = dot, 1 = dash; unused upper bits are 0.

## Operation
- **Supported characters:** ITU codes for A–Z, 0–9 and . , ? ' / ( ) & : ; = + - _ @, plus ! = -.-.--.
  - a–z map to A–Z.
  - Space (0x20) is a word gap.
  - Every other code is unsupported.
- **Handshake:** a character is accepted in any cycle where char_valid && char_ready.
  - char_data is sampled only in that cycle.
  - Lookup is combinational on char_data.
  - The result is registered into morse_length, morse_input, a shift register and a symbol counter.
- **States:**
  - IDLE → MARK: on a supported non-space character.
  - IDLE → WGAP: on space.
  - IDLE → IDLE: on an unsupported character; err pulses; no key activity.
  - MARK: key_out = 1 for 1 unit (dot) or 3 units (dash). Then SGAP if symbols remain, else LGAP.
  - SGAP: key_out = 0 for 1 unit, then MARK with the next symbol.
  - LGAP: key_out = 0 for 3 units, then IDLE with a done pulse.
  - WGAP: key_out = 0 for 4 units (the preceding 3-unit letter gap completes the 7-unit word gap), then IDLE with a done pulse.
- **Timer:** a cycle counter runs 0..UNIT_CYCLES-1; a unit counter runs 0..3. Both clear on every state change.
- **Held outputs:** morse_length and morse_input hold from acceptance until the next acceptance.
- **char_valid while busy:** ignored. The character is not lost if the source holds it, since it is accepted on return to IDLE.

## Timing
- **Reset (rst_n sampled low):** next cycle, all outputs are 0, the state is IDLE and the counters are 0.
  - Applies mid-character: the tone stops immediately and the character is dropped, with no done and no err.
  - char_ready = 1 from the cycle after rst_n is first sampled high.
- **Cycle numbering:** take the handshake cycle as cycle 0. U = UNIT_CYCLES.
- **Supported character:**
  - key_out rises in cycle 1.
  - The character occupies (Σ mark units + (n−1) + 3)·U cycles, starting at cycle 1.
  - With that total as T: done = 1 and char_ready = 1 in cycle T+1; busy = 0 in cycle T+1.
- **Space:** key_out stays 0; done and char_ready in cycle 4U+1.
- **Unsupported character:** err = 1 in cycle 1; char_ready stays 1 throughout; busy stays 0.
- **Back-to-back:**
  - char_valid held high → the next character is accepted in the done cycle.
  - Its first mark begins the following cycle.
  - Minimum inter-letter silence is therefore 3U+1 cycles.
- All outputs are registered; no combinational path from input to output.
- **UNIT_CYCLES = 1:** must work. Each unit is exactly 1 cycle.

## Test plan
1. **'E' (0x45):** U=4, handshake at cycle 0.
   - key_out = 1 in cycles 1–4, 0 in cycles 5–16.
   - done and char_ready in cycle 17.
   - morse_length=1, morse_input=0x00.
2. **'A' then 'a' held on char_valid:** U=4.
   - Each character gives key high 4, low 4, high 12, low 12.
   - The second accept happens in the first character's done cycle (33); the second key rise is in cycle 34.
   - Both characters report morse_length=2, morse_input=0x01.
3. **'0' (0x30):** U=2.
   - Five 6-cycle marks separated by 2-cycle gaps, then 6 cycles low.
   - done in cycle 45; morse_length=5, morse_input=0x1F.
4. **'#' (0x23):** err=1 in cycle 1 only; key_out, busy and done stay 0; char_ready never drops.
5. **"S S" with U=1:**
   - 'S': key 1,0,1,0,1 then 3 low.
   - Space: 4 low.
   - 'S': same pattern as the first.
   - Space reports morse_length=0.
6. **Reset and loopback:**
   - Assert rst_n=0 during the dash of 'T': key_out = 0 the next cycle; no done; char_ready = 1 the cycle after release.
   - Loopback: for every supported character, morse_length and morse_input fed to the decoder yield that same character.
